exec_stage16: RTL and testbench



---
 rtl/exec16_pkg.sv | 42 ++++
 rtl/exec_stage16_mul16_seq.sv | 52 +++++
 rtl/exec_stage16.sv | 177 +++++++++++++++++
 tb/tb_exec_stage16.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/exec16_pkg.sv
// Shared opcodes, FSM encoding and instruction field positions for exec_stage16.
package exec16_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_ADDI = 4'd8;
  localparam logic [3:0] OP_MOVI = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MULT = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  localparam int OP_HI   = 15;
  localparam int OP_LO   = 12;
  localparam int RD_HI   = 11;
  localparam int RD_LO   = 9;
  localparam int RA_HI   = 8;
  localparam int RA_LO   = 6;
  localparam int RB_HI   = 5;
  localparam int RB_LO   = 3;
  localparam int IMM6_HI = 5;
  localparam int IMM9_HI = 8;

  function automatic logic signed [15:0] sext6(input logic [5:0] v);
    return {{10{v[5]}}, v};
  endfunction

  function automatic logic signed [15:0] sext9(input logic [8:0] v);
    return {{7{v[8]}}, v};
  endfunction

endpackage

// File: rtl/exec_stage16_mul16_seq.sv
// Shift-add multiplier: 16 iterations after start, product is the low 16 bits.
module mul16_seq
  import exec16_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        last,
  output logic [15:0] product
);

  logic [15:0] mcand_p1;
  logic [15:0] mplier_p1;
  logic [15:0] acc_p1;
  logic [15:0] acc_nxt;
  logic [3:0]  cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= 4'd0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= 4'd0;
    end else if (busy) begin
      cnt <= cnt + 4'd1;
      if (cnt == 4'd15) busy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      mcand_p1  <= a;
      mplier_p1 <= b;
      acc_p1    <= 16'd0;
    end else if (busy) begin
      acc_p1    <= acc_nxt;
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
    end
  end

  // product is the accumulator value after this cycle's update, so on the
  // last iteration it already holds the final result
  assign acc_nxt = acc_p1 + (mplier_p1[0] ? mcand_p1 : 16'd0);
  assign product = acc_nxt;
  assign last    = busy && (cnt == 4'd15);

endmodule

// File: rtl/exec_stage16.sv
// Execute/write-back stage driving an 8x16 register file.
// Define EXEC16_MUL_EN to build the multicycle MUL (op 10); otherwise op 10 is illegal.
module exec_stage16
  import exec16_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  output logic [2:0]  rdAddrA,
  output logic [2:0]  rdAddrB,
  input  logic [15:0] rdDataA,
  input  logic [15:0] rdDataB,
  output logic        write,
  output logic [2:0]  wrAddr,
  output logic [15:0] wrData,
  output logic        done,
  output logic        illegal,
  output logic        flag_z,
  output logic        flag_c
);

  state_t state, state_nxt;

  logic [15:0]        ir_p0;
  logic [3:0]         op;
  logic [2:0]         rd;
  logic               accept;
  logic               is_mul;
  logic               is_illegal;
  logic               wr_op;
  logic               flag_op;
  logic               mul_start;
  logic signed [15:0] opa;
  logic signed [15:0] opb;
  logic signed [15:0] alu_res;
  logic               alu_c;
  logic [16:0]        sum17;
  logic               write_p1;
  logic               done_p1;
  logic               illegal_p1;

  assign op      = ir_p0[OP_HI:OP_LO];
  assign rd      = ir_p0[RD_HI:RD_LO];
  assign rdAddrA = ir_p0[RA_HI:RA_LO];
  assign rdAddrB = ir_p0[RB_HI:RB_LO];
  assign opa     = $signed(rdDataA);
  assign opb     = $signed(rdDataB);
  assign accept  = in_valid && in_ready;

`ifdef EXEC16_MUL_EN
  logic        mul_busy;
  logic        mul_last;
  logic [15:0] mul_product;

  assign is_mul     = (op == OP_MUL);
  assign is_illegal = (op > OP_MUL);

  mul16_seq u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (rdDataA),
    .b       (rdDataB),
    .busy    (mul_busy),
    .last    (mul_last),
    .product (mul_product)
  );
`else
  assign is_mul     = 1'b0;
  assign is_illegal = (op >= OP_MUL);
`endif

  assign wr_op   = (op != OP_NOP) && !is_illegal;
  assign flag_op = wr_op && (op != OP_MOVI);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    sum17   = '0;
    case (op)
      OP_ADD: begin
        sum17   = {1'b0, opa} + {1'b0, opb};
        alu_res = sum17[15:0];
        alu_c   = sum17[16];
      end
      OP_SUB: begin
        alu_res = opa - opb;
        alu_c   = $unsigned(opa) < $unsigned(opb);
      end
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      OP_SHL:  alu_res = opa << opb[3:0];
      OP_SHR:  alu_res = $unsigned(opa) >> opb[3:0];
      OP_ADDI: begin
        sum17   = {1'b0, opa} + {1'b0, sext6(ir_p0[IMM6_HI:0])};
        alu_res = sum17[15:0];
        alu_c   = sum17[16];
      end
      OP_MOVI: alu_res = sext9(ir_p0[IMM9_HI:0]);
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = is_mul ? ST_MULT : ST_WB;
`ifdef EXEC16_MUL_EN
      ST_MULT: if (mul_last) state_nxt = ST_WB;
`endif
      ST_WB:   state_nxt = accept ? ST_EXEC : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    mul_start = 1'b0;
    if (!reset) in_ready = (state == ST_IDLE) || (state == ST_WB);
    if (state == ST_EXEC) mul_start = is_mul;
  end

  // EXEC/MULT -> WB boundary: results registered for the write-back cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_p0      <= '0;
      write_p1   <= 1'b0;
      done_p1    <= 1'b0;
      illegal_p1 <= 1'b0;
      wrAddr     <= '0;
      wrData     <= '0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
    end else begin
      write_p1   <= 1'b0;
      done_p1    <= 1'b0;
      illegal_p1 <= 1'b0;
      if (accept) ir_p0 <= in_instr;
      if (state == ST_EXEC && !is_mul) begin
        write_p1   <= wr_op;
        done_p1    <= 1'b1;
        illegal_p1 <= is_illegal;
        wrAddr     <= rd;
        wrData     <= alu_res;
        if (flag_op) begin
          flag_z <= (alu_res == 16'sd0);
          flag_c <= alu_c;
        end
      end
`ifdef EXEC16_MUL_EN
      if (state == ST_MULT && mul_last) begin
        write_p1 <= 1'b1;
        done_p1  <= 1'b1;
        wrAddr   <= rd;
        wrData   <= mul_product;
        flag_z   <= (mul_product == 16'd0);
        flag_c   <= 1'b0;
      end
`endif
    end
  end

  // a reset arriving during WB must still suppress the commit and the pulse
  assign write   = write_p1   && !reset;
  assign done    = done_p1    && !reset;
  assign illegal = illegal_p1 && !reset;

endmodule

// File: tb/tb_exec_stage16.sv
// Directed bench for exec_stage16 with a behavioural 8x16 register file.
module tb_exec_stage16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = 16'd0;
  logic [2:0]  rdAddrA, rdAddrB;
  logic [15:0] rdDataA, rdDataB;
  logic        write;
  logic [2:0]  wrAddr;
  logic [15:0] wrData;
  logic        done, illegal, flag_z, flag_c;

  logic [15:0] rf [8];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  exec_stage16 dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .rdAddrA(rdAddrA), .rdAddrB(rdAddrB), .rdDataA(rdDataA), .rdDataB(rdDataB),
    .write(write), .wrAddr(wrAddr), .wrData(wrData), .done(done), .illegal(illegal),
    .flag_z(flag_z), .flag_c(flag_c)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (write) rf[wrAddr] <= wrData;
  assign rdDataA = rf[rdAddrA];
  assign rdDataB = rf[rdAddrB];

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
    return {op, rd, ra, rb, 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra, input logic [5:0] imm);
    return {op, rd, ra, imm};
  endfunction

  function automatic logic [15:0] enc_movi(input logic [2:0] rd, input logic [8:0] imm);
    return {4'd9, rd, imm};
  endfunction

  // Issue one instruction and capture the write-back cycle; latency counts EXEC as 1.
  task automatic do_instr(input logic [15:0] ins, output int lat, output logic w, output logic [2:0] wa,
                          output logic [15:0] wd, output logic ill, output logic fz, output logic fc);
    int n;
    int acc_cyc;
    lat = -1; w = 1'b0; wa = 3'd0; wd = 16'd0; ill = 1'b0; fz = 1'b0; fc = 1'b0;
    @(negedge clk);
    in_instr = ins;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout instr=%h in_ready=%b required=1", ins, in_ready);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    acc_cyc = cyc;
    in_valid = 1'b0;
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    if (done) begin
      lat = cyc - acc_cyc + 1;
      w = write; wa = wrAddr; wd = wrData; ill = illegal; fz = flag_z; fc = flag_c;
    end else begin
      total++; bad++;
      $display("FAIL done_timeout instr=%h done=%b required=1", ins, done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    total++; if ({write, done, illegal} !== 3'b000) begin bad++; $display("FAIL rst_pulses got=%b exp=000", {write, done, illegal}); end
    total++; if ({flag_z, flag_c} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b exp=00", {flag_z, flag_c}); end
    total++; if ({rdAddrA, rdAddrB, wrAddr} !== 9'd0) begin bad++; $display("FAIL rst_addrs got=%h exp=0", {rdAddrA, rdAddrB, wrAddr}); end
    total++; if (wrData !== 16'd0) begin bad++; $display("FAIL rst_wrdata got=%h exp=0000", wrData); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_movi;
    int lat; logic w, ill, fz, fc; logic [2:0] wa; logic [15:0] wd;
    do_instr(enc_movi(3'd1, 9'd5), lat, w, wa, wd, ill, fz, fc);
    total++; if (lat !== 2) begin bad++; $display("FAIL movi1_latency got=%0d exp=2", lat); end
    total++; if ({w, wa, wd} !== {1'b1, 3'd1, 16'h0005}) begin bad++; $display("FAIL movi1_write got=%b/%0d/%h exp=1/1/0005", w, wa, wd); end
    total++; if (rf[1] !== 16'h0005) begin bad++; $display("FAIL movi1_rf got=%h exp=0005", rf[1]); end
    do_instr(enc_movi(3'd2, 9'h1FD), lat, w, wa, wd, ill, fz, fc);
    total++; if (lat !== 2) begin bad++; $display("FAIL movi2_latency got=%0d exp=2", lat); end
    total++; if ({w, wa, wd} !== {1'b1, 3'd2, 16'hFFFD}) begin bad++; $display("FAIL movi2_write got=%b/%0d/%h exp=1/2/fffd", w, wa, wd); end
    total++; if ({fz, fc} !== 2'b00) begin bad++; $display("FAIL movi_flags got=%b exp=00", {fz, fc}); end
    total++; if (rf[2] !== 16'hFFFD) begin bad++; $display("FAIL movi2_rf got=%h exp=fffd", rf[2]); end
  endtask

  task automatic test_add_sub;
    int lat; logic w, ill, fz, fc; logic [2:0] wa; logic [15:0] wd;
    do_instr(enc_r(4'd1, 3'd3, 3'd1, 3'd2), lat, w, wa, wd, ill, fz, fc);
    total++; if ({w, wa, wd} !== {1'b1, 3'd3, 16'h0002}) begin bad++; $display("FAIL add_write got=%b/%0d/%h exp=1/3/0002", w, wa, wd); end
    total++; if ({fz, fc} !== 2'b01) begin bad++; $display("FAIL add_flags zc got=%b exp=01", {fz, fc}); end
    total++; if (rf[3] !== 16'h0002) begin bad++; $display("FAIL add_rf got=%h exp=0002", rf[3]); end
    do_instr(enc_r(4'd2, 3'd4, 3'd1, 3'd1), lat, w, wa, wd, ill, fz, fc);
    total++; if ({w, wa, wd} !== {1'b1, 3'd4, 16'h0000}) begin bad++; $display("FAIL sub_write got=%b/%0d/%h exp=1/4/0000", w, wa, wd); end
    total++; if ({fz, fc} !== 2'b10) begin bad++; $display("FAIL sub_flags zc got=%b exp=10", {fz, fc}); end
  endtask

  task automatic test_back_to_back;
    int n, acc1, acc2;
    @(negedge clk);
    in_instr = enc_i(4'd8, 3'd1, 3'd1, 6'd1);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
    acc1 = cyc;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_exec_ready got=%b exp=0", in_ready); end
    @(negedge clk);
    total++; if ({done, write, wrData} !== {2'b11, 16'h0006}) begin bad++; $display("FAIL b2b_first got=%b%b/%h exp=11/0006", done, write, wrData); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_wb_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    acc2 = cyc;
    in_valid = 1'b0;
    total++; if (acc2 - acc1 !== 2) begin bad++; $display("FAIL b2b_spacing got=%0d exp=2", acc2 - acc1); end
    total++; if (rf[1] !== 16'h0006) begin bad++; $display("FAIL b2b_rf_mid got=%h exp=0006", rf[1]); end
    @(negedge clk);
    total++; if ({done, write, wrData} !== {2'b11, 16'h0007}) begin bad++; $display("FAIL b2b_second got=%b%b/%h exp=11/0007", done, write, wrData); end
    @(negedge clk);
    total++; if (rf[1] !== 16'h0007) begin bad++; $display("FAIL b2b_rf_end got=%h exp=0007", rf[1]); end
  endtask

  task automatic test_shift;
    int lat; logic w, ill, fz, fc; logic [2:0] wa; logic [15:0] wd;
    do_instr(enc_movi(3'd5, 9'd1), lat, w, wa, wd, ill, fz, fc);
    do_instr(enc_movi(3'd6, 9'd15), lat, w, wa, wd, ill, fz, fc);
    do_instr(enc_r(4'd6, 3'd7, 3'd5, 3'd6), lat, w, wa, wd, ill, fz, fc);
    total++; if (wd !== 16'h8000) begin bad++; $display("FAIL shl15 got=%h exp=8000", wd); end
    do_instr(enc_r(4'd4, 3'd5, 3'd7, 3'd5), lat, w, wa, wd, ill, fz, fc);
    total++; if (wd !== 16'h8001) begin bad++; $display("FAIL or_build got=%h exp=8001", wd); end
    do_instr(enc_movi(3'd6, 9'd1), lat, w, wa, wd, ill, fz, fc);
    do_instr(enc_r(4'd6, 3'd7, 3'd5, 3'd6), lat, w, wa, wd, ill, fz, fc);
    total++; if ({w, wa, wd} !== {1'b1, 3'd7, 16'h0002}) begin bad++; $display("FAIL shl1 got=%b/%0d/%h exp=1/7/0002", w, wa, wd); end
    total++; if ({fz, fc} !== 2'b00) begin bad++; $display("FAIL shl_flags got=%b exp=00", {fz, fc}); end
    do_instr(enc_r(4'd7, 3'd7, 3'd5, 3'd6), lat, w, wa, wd, ill, fz, fc);
    total++; if (wd !== 16'h4000) begin bad++; $display("FAIL shr1 got=%h exp=4000", wd); end
    total++; if (rf[7] !== 16'h4000) begin bad++; $display("FAIL shr_rf got=%h exp=4000", rf[7]); end
  endtask

  task automatic test_mul;
    int lat; logic w, ill, fz, fc; logic [2:0] wa; logic [15:0] wd;
    do_instr(enc_r(4'd10, 3'd6, 3'd1, 3'd2), lat, w, wa, wd, ill, fz, fc);
`ifdef EXEC16_MUL_EN
    total++; if (lat !== 18) begin bad++; $display("FAIL mul_latency got=%0d exp=18", lat); end
    total++; if ({w, ill, wa, wd} !== {2'b10, 3'd6, 16'hFFEB}) begin bad++; $display("FAIL mul_write got=%b%b/%0d/%h exp=10/6/ffeb", w, ill, wa, wd); end
    total++; if ({fz, fc} !== 2'b00) begin bad++; $display("FAIL mul_flags got=%b exp=00", {fz, fc}); end
    total++; if (rf[6] !== 16'hFFEB) begin bad++; $display("FAIL mul_rf got=%h exp=ffeb", rf[6]); end
`else
    total++; if (lat !== 2) begin bad++; $display("FAIL mul_off_latency got=%0d exp=2", lat); end
    total++; if ({w, ill} !== 2'b01) begin bad++; $display("FAIL mul_off_pulses w/ill got=%b exp=01", {w, ill}); end
    total++; if (rf[6] !== 16'h0001) begin bad++; $display("FAIL mul_off_rf got=%h exp=0001", rf[6]); end
`endif
  endtask

  task automatic test_reset_abort;
    int n;
    int wait_n;
    logic seen;
`ifdef EXEC16_MUL_EN
    in_instr = enc_r(4'd10, 3'd3, 3'd1, 3'd2);
    wait_n = 5;
`else
    in_instr = enc_r(4'd1, 3'd3, 3'd1, 3'd2);
    wait_n = 0;
`endif
    @(negedge clk);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (wait_n) @(negedge clk);
    reset = 1'b1;
    #1 seen = write | done;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL abort_ready_in_reset got=%b exp=0", in_ready); end
    seen = seen | write | done;
    reset = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_ready_after got=%b exp=1", in_ready); end
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      seen = seen | write | done;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_write_done got=%b exp=0", seen); end
    total++; if (rf[3] !== 16'h0002) begin bad++; $display("FAIL abort_rf got=%h exp=0002", rf[3]); end
    total++; if ({flag_z, flag_c} !== 2'b00) begin bad++; $display("FAIL abort_flags got=%b exp=00", {flag_z, flag_c}); end
  endtask

  task automatic test_illegal;
    int lat; logic w, ill, fz, fc; logic [2:0] wa; logic [15:0] wd;
    do_instr(enc_r(4'd2, 3'd4, 3'd1, 3'd1), lat, w, wa, wd, ill, fz, fc);
    total++; if ({fz, fc} !== 2'b10) begin bad++; $display("FAIL ill_pre_flags got=%b exp=10", {fz, fc}); end
    do_instr(enc_r(4'd15, 3'd1, 3'd2, 3'd3), lat, w, wa, wd, ill, fz, fc);
    total++; if (lat !== 2) begin bad++; $display("FAIL ill_latency got=%0d exp=2", lat); end
    total++; if ({w, ill} !== 2'b01) begin bad++; $display("FAIL ill_pulses w/ill got=%b exp=01", {w, ill}); end
    total++; if ({fz, fc} !== 2'b10) begin bad++; $display("FAIL ill_flags_held got=%b exp=10", {fz, fc}); end
    total++; if (rf[1] !== 16'h0007) begin bad++; $display("FAIL ill_rf got=%h exp=0007", rf[1]); end
    do_instr(enc_r(4'd0, 3'd1, 3'd0, 3'd0), lat, w, wa, wd, ill, fz, fc);
    total++; if ({lat == 2, w, ill} !== 3'b100) begin bad++; $display("FAIL nop got lat=%0d w=%b ill=%b exp lat=2 w=0 ill=0", lat, w, ill); end
  endtask

  initial begin
    test_reset;
    test_movi;
    test_add_sub;
    test_back_to_back;
    test_shift;
    test_mul;
    test_reset_abort;
    test_illegal;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
